pattern_sequencer: RTL and testbench

Parametrised one-hot pattern sequencer driving the board LED bank. It generalises the fixed 8-bit two-pass right/left sweep into a WIDTH-bit engine with four modes, a programmable step prescaler and a start/stop control FSM. The block sits between the front-panel control logic (start/stop/mode) and the LED output register. It emits a one-clock marker at the end of every full pattern period.

---
 rtl/pattern_seq_pkg.sv | 23 ++
 rtl/pattern_step.sv | 77 +++++++
 rtl/pattern_sequencer.sv | 125 ++++++++++++
 tb/tb_pattern_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// rtl/pattern_seq_pkg.sv - shared types for the LED pattern sequencer
package pattern_seq_pkg;

  // Pattern modes as encoded on the mode input
  typedef enum logic [1:0] {
    MODE_ROT_R  = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Control FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only ROT_L starts at the LSB travelling left; every other mode starts at the MSB
  function automatic logic starts_left(input mode_e m);
    return (m == MODE_ROT_L);
  endfunction

endpackage

// File: rtl/pattern_step.sv
// rtl/pattern_step.sv - combinational next-step rule for one pattern step
import pattern_seq_pkg::*;

module pattern_step #(
  parameter int WIDTH  = 8,
  parameter int PASSES = 2,
  parameter int PW     = $clog2(2*PASSES)
) (
  input  logic [WIDTH-1:0] pattern,
  input  logic             dir,
  input  logic [PW-1:0]    pass_idx,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_pattern,
  output logic             next_dir,
  output logic [PW-1:0]    next_pass_idx,
  output logic             period_flag
);

  localparam logic [WIDTH-1:0] MSB_HOT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_HOT = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_end;
  int   passes_eff;
  int   pos;

  // The single set bit has reached the edge it is travelling toward
  assign at_end = dir ? (pattern == MSB_HOT) : (pattern == LSB_HOT);

  // Pass position within the current direction; BOUNCE is a one-pass sweep
  always_comb begin
    passes_eff = (mode == MODE_BOUNCE) ? 1 : PASSES;
    pos        = dir ? (int'(pass_idx) - passes_eff) : int'(pass_idx);
  end

  // Shift toward the current direction, or apply the mode's end-of-travel rule
  always_comb begin
    next_pattern  = pattern;
    next_dir      = dir;
    next_pass_idx = pass_idx;
    period_flag   = 1'b0;
    if (!at_end) begin
      next_pattern = dir ? (pattern << 1) : (pattern >> 1);
    end else begin
      case (mode)
        MODE_ROT_R: begin
          next_pattern  = MSB_HOT;
          next_dir      = 1'b0;
          next_pass_idx = '0;
          period_flag   = 1'b1;
        end
        MODE_ROT_L: begin
          next_pattern  = LSB_HOT;
          next_dir      = 1'b1;
          next_pass_idx = '0;
          period_flag   = 1'b1;
        end
        default: begin
          if (pos < passes_eff - 1) begin
            // Another pass in the same direction: jump back to the far end
            next_pattern  = dir ? LSB_HOT : MSB_HOT;
            next_pass_idx = pass_idx + PW'(1);
          end else begin
            // Last pass of this direction: hold one step and turn around
            next_dir = ~dir;
            if (dir) begin
              next_pass_idx = '0;
              period_flag   = 1'b1;
            end else begin
              next_pass_idx = pass_idx + PW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - start/stop FSM, step prescaler and LED pattern registers
import pattern_seq_pkg::*;

module pattern_sequencer #(
  parameter int WIDTH  = 8,
  parameter int PASSES = 2,
  parameter int DIV_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [1:0]                    mode,
  input  logic [DIV_W-1:0]              div,
  output logic [WIDTH-1:0]              pattern,
  output logic                          busy,
  output logic                          dir,
  output logic [$clog2(2*PASSES)-1:0]   pass_idx,
  output logic                          period
);

  localparam int PW = $clog2(2*PASSES);
  localparam logic [WIDTH-1:0] MSB_HOT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_HOT = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  mode_e            mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;

  mode_e            mode_in;
  logic             load_dir;
  logic [WIDTH-1:0] load_pattern;

  logic [WIDTH-1:0] step_pattern;
  logic             step_dir;
  logic [PW-1:0]    step_pass_idx;
  logic             step_period;

  // Start state derived from the live mode input; only sampled on an accepted start
  always_comb begin
    mode_in      = mode_e'(mode);
    load_dir     = starts_left(mode_in);
    load_pattern = load_dir ? LSB_HOT : MSB_HOT;
  end

  pattern_step #(
    .WIDTH  (WIDTH),
    .PASSES (PASSES),
    .PW     (PW)
  ) u_step (
    .pattern       (pattern),
    .dir           (dir),
    .pass_idx      (pass_idx),
    .mode          (mode_q),
    .next_pattern  (step_pattern),
    .next_dir      (step_dir),
    .next_pass_idx (step_pass_idx),
    .period_flag   (step_period)
  );

  // Control FSM with prescaler and registered outputs; stop outranks start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_ROT_R;
      div_q    <= '0;
      presc    <= '0;
      pattern  <= '0;
      busy     <= 1'b0;
      dir      <= 1'b0;
      pass_idx <= '0;
      period   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state    <= ST_RUN;
            mode_q   <= mode_in;
            div_q    <= div;
            presc    <= '0;
            pattern  <= load_pattern;
            dir      <= load_dir;
            pass_idx <= '0;
            period   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state    <= ST_IDLE;
            presc    <= '0;
            pattern  <= '0;
            dir      <= 1'b0;
            pass_idx <= '0;
            period   <= 1'b0;
            busy     <= 1'b0;
          end else if (start) begin
            mode_q   <= mode_in;
            div_q    <= div;
            presc    <= '0;
            pattern  <= load_pattern;
            dir      <= load_dir;
            pass_idx <= '0;
            period   <= 1'b0;
          end else if (presc == div_q) begin
            presc    <= '0;
            pattern  <= step_pattern;
            dir      <= step_dir;
            pass_idx <= step_pass_idx;
            period   <= step_period;
          end else begin
            presc  <= presc + DIV_W'(1);
            period <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] div;
  logic [7:0] pattern;
  logic       busy;
  logic       dir;
  logic [1:0] pass_idx;
  logic       period;

  int passed;
  int failed;
  int total;

  pattern_sequencer #(
    .WIDTH  (8),
    .PASSES (2),
    .DIV_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div      (div),
    .pattern  (pattern),
    .busy     (busy),
    .dir      (dir),
    .pass_idx (pass_idx),
    .period   (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e_pat;
    logic       e_dir;
    logic [1:0] e_pi;
    logic       e_per;

    passed = 0;
    failed = 0;
    total  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = 2'd0;
    div    = 8'd0;

    // Reset state
    repeat (2) tick();
    check("reset_pattern", pattern, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_dir", dir, 1'b0);
    check("reset_pass_idx", pass_idx, 2'd0);
    check("reset_period", period, 1'b0);
    rst_n = 1'b1;
    tick();

    // start and stop together in IDLE stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check("idle_startstop_busy", busy, 1'b0);
    check("idle_startstop_pattern", pattern, 8'h00);
    start = 1'b0;
    stop  = 1'b0;

    // ROT_R, div=0
    mode  = 2'd0;
    div   = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rotr_start_pattern", pattern, 8'h80);
    check("rotr_start_busy", busy, 1'b1);
    check("rotr_start_period", period, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      e_pat = 8'h80 >> k;
      check("rotr_step_pattern", pattern, e_pat);
      check("rotr_step_period", period, 1'b0);
    end
    tick();
    check("rotr_wrap_pattern", pattern, 8'h80);
    check("rotr_wrap_period", period, 1'b1);
    check("rotr_wrap_busy", busy, 1'b1);
    tick();
    check("rotr_after_wrap_pattern", pattern, 8'h40);
    check("rotr_after_wrap_period", period, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("rotr_stop_busy", busy, 1'b0);
    check("rotr_stop_pattern", pattern, 8'h00);

    // SWEEP, PASSES=2, div=0: 32-step period
    mode  = 2'd2;
    div   = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sweep_start_pattern", pattern, 8'h80);
    for (int s = 1; s <= 32; s++) begin
      tick();
      if (s <= 7)       begin e_pat = 8'h80 >> s;        e_dir = 1'b0; e_pi = 2'd0; end
      else if (s == 8)  begin e_pat = 8'h80;             e_dir = 1'b0; e_pi = 2'd1; end
      else if (s <= 15) begin e_pat = 8'h80 >> (s - 8);  e_dir = 1'b0; e_pi = 2'd1; end
      else if (s == 16) begin e_pat = 8'h01;             e_dir = 1'b1; e_pi = 2'd2; end
      else if (s <= 23) begin e_pat = 8'h01 << (s - 16); e_dir = 1'b1; e_pi = 2'd2; end
      else if (s == 24) begin e_pat = 8'h01;             e_dir = 1'b1; e_pi = 2'd3; end
      else if (s <= 31) begin e_pat = 8'h01 << (s - 24); e_dir = 1'b1; e_pi = 2'd3; end
      else              begin e_pat = 8'h80;             e_dir = 1'b0; e_pi = 2'd0; end
      e_per = (s == 32);
      check("sweep_pattern", pattern, e_pat);
      check("sweep_dir", dir, e_dir);
      check("sweep_pass_idx", pass_idx, e_pi);
      check("sweep_period", period, e_per);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // BOUNCE, div=3: steps every 4 clocks, period after 64 clocks
    mode  = 2'd3;
    div   = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bounce_start_pattern", pattern, 8'h80);
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c == 3) check("bounce_hold_pattern", pattern, 8'h80);
      if (c == 4) check("bounce_first_step", pattern, 8'h40);
      if (c == 32) begin
        check("bounce_turn_pattern", pattern, 8'h01);
        check("bounce_turn_dir", dir, 1'b1);
        check("bounce_turn_pass_idx", pass_idx, 2'd1);
      end
      if (c == 63) begin
        check("bounce_pre_period", period, 1'b0);
        check("bounce_pre_dir", dir, 1'b1);
      end
      if (c == 64) begin
        check("bounce_period", period, 1'b1);
        check("bounce_period_pattern", pattern, 8'h80);
        check("bounce_period_dir", dir, 1'b0);
        check("bounce_period_pass_idx", pass_idx, 2'd0);
      end
      if (c == 65) check("bounce_post_period", period, 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Stop on the same edge a step is due
    mode  = 2'd0;
    div   = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("stopdue_before", pattern, 8'h80);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopdue_pattern", pattern, 8'h00);
    check("stopdue_busy", busy, 1'b0);
    check("stopdue_period", period, 1'b0);

    // Restart in RUN at 0x08 reloads the start value and clears the prescaler
    mode  = 2'd0;
    div   = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("restart_at_08", pattern, 8'h08);
    tick();
    check("restart_mid_prescale", pattern, 8'h08);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_reload", pattern, 8'h80);
    check("restart_busy", busy, 1'b1);
    tick();
    check("restart_presc_cleared", pattern, 8'h80);
    tick();
    check("restart_first_step", pattern, 8'h40);

    // mode/div changes in RUN are ignored until the next start
    mode = 2'd1;
    div  = 8'd0;
    tick();
    check("latch_div_held", pattern, 8'h40);
    tick();
    check("latch_mode_still_right", pattern, 8'h20);
    check("latch_dir_still_right", dir, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rotl_start_pattern", pattern, 8'h01);
    check("rotl_start_dir", dir, 1'b1);
    tick();
    check("rotl_first_step", pattern, 8'h02);
    for (int k = 2; k <= 7; k++) begin
      tick();
      e_pat = 8'h01 << k;
      check("rotl_step_pattern", pattern, e_pat);
    end
    tick();
    check("rotl_wrap_pattern", pattern, 8'h01);
    check("rotl_wrap_period", period, 1'b1);
    check("rotl_wrap_dir", dir, 1'b1);

    // Asynchronous reset mid-run, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pattern", pattern, 8'h00);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_period", period, 1'b0);
    check("async_reset_dir", dir, 1'b0);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
